// File: rtl/turfio_wb_pkg.sv
// Shared types and widths for the TURFIO Wishbone register-bus arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package turfio_wb_pkg;

    localparam int TURFIO_WB_ADR_W = 25;
    localparam int TURFIO_WB_DAT_W = 32;
    localparam int TURFIO_WB_SEL_W = TURFIO_WB_DAT_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Master-to-slave request bundle.
    typedef struct packed {
        logic                       cyc;
        logic                       stb;
        logic                       we;
        logic [TURFIO_WB_ADR_W-1:0] adr;
        logic [TURFIO_WB_DAT_W-1:0] dat;
        logic [TURFIO_WB_SEL_W-1:0] sel;
    } wb_req_t;

    // Slave-to-master response bundle.
    typedef struct packed {
        logic [TURFIO_WB_DAT_W-1:0] dat;
        logic                       ack;
        logic                       err;
        logic                       rty;
    } wb_rsp_t;

    // One-hot owner encoding for a state; 00 when idle.
    function automatic logic [1:0] state_grant(input arb_state_t s);
        case (s)
            OWN0:    return 2'b01;
            OWN1:    return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/turfio_wb_watchdog.sv
// Bus-stall watchdog: counts owner stb cycles with no slave termination and fires once at the limit.
// Latency: expire is combinational from the registered count, asserted on the TIMEOUT_CYCLES-th stalled cycle.
// Backpressure: after expiry, block holds the owner's strobe off until the owner drops stb itself.
// Ports: clk/rst_n; own_vld (a master owns the bus), own_stb (owner strobe), term (any slave termination);
//        expire (one-cycle pulse), block (strobe suppression).
module turfio_wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic own_vld,
    input  logic own_stb,
    input  logic term,
    output logic expire,
    output logic block
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             block_q;

    // A stalled strobe that has already been killed must not fire again.
    assign expire = own_vld & own_stb & ~block_q & (cnt == LIMIT);
    assign block  = block_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            block_q <= 1'b0;
        end else if (!own_vld) begin
            cnt     <= '0;
            block_q <= 1'b0;
        end else if (expire) begin
            cnt     <= '0;
            block_q <= 1'b1;
        end else if (block_q) begin
            cnt <= '0;
            if (!own_stb) begin
                block_q <= 1'b0;
            end
        end else if (!own_stb || term) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/turfio_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter for the TURFIO register bus; grant locked for a whole cyc.
// Latency: one clock of arbitration (s_cyc_o rises the edge after mx_cyc_i); data path is combinational.
// Backpressure: losing master waits with no termination; a hung slave is cut off only with TURFIO_WB_ARB_TIMEOUT_EN.
// Ports: m0_* (board-manager bridge) and m1_* (TURF control) Wishbone masters, s_* single slave,
//        grant_o one-hot owner (00 idle), timeout_o watchdog expiry pulse.
// Build option: define TURFIO_WB_ARB_TIMEOUT_EN to include the bus-timeout watchdog.
module turfio_wb_arbiter
    import turfio_wb_pkg::*;
#(
    parameter int ADR_W          = TURFIO_WB_ADR_W,
    parameter int DAT_W          = TURFIO_WB_DAT_W,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               m0_cyc_i,
    input  logic               m0_stb_i,
    input  logic               m0_we_i,
    input  logic [ADR_W-1:0]   m0_adr_i,
    input  logic [DAT_W-1:0]   m0_dat_i,
    input  logic [DAT_W/8-1:0] m0_sel_i,
    output logic [DAT_W-1:0]   m0_dat_o,
    output logic               m0_ack_o,
    output logic               m0_err_o,
    output logic               m0_rty_o,
    input  logic               m1_cyc_i,
    input  logic               m1_stb_i,
    input  logic               m1_we_i,
    input  logic [ADR_W-1:0]   m1_adr_i,
    input  logic [DAT_W-1:0]   m1_dat_i,
    input  logic [DAT_W/8-1:0] m1_sel_i,
    output logic [DAT_W-1:0]   m1_dat_o,
    output logic               m1_ack_o,
    output logic               m1_err_o,
    output logic               m1_rty_o,
    output logic               s_cyc_o,
    output logic               s_stb_o,
    output logic               s_we_o,
    output logic [ADR_W-1:0]   s_adr_o,
    output logic [DAT_W-1:0]   s_dat_o,
    output logic [DAT_W/8-1:0] s_sel_o,
    input  logic [DAT_W-1:0]   s_dat_i,
    input  logic               s_ack_i,
    input  logic               s_err_i,
    input  logic               s_rty_i,
    output logic [1:0]         grant_o,
    output logic               timeout_o
);

    arb_state_t state;
    logic [1:0] grant_q;
    logic       last_owner;   // index of the master that most recently released the bus

    wb_req_t req0, req1, s_req;
    wb_rsp_t own_rsp;
    logic    wd_expire, wd_block;

    assign req0 = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i, adr: m0_adr_i, dat: m0_dat_i, sel: m0_sel_i};
    assign req1 = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i, adr: m1_adr_i, dat: m1_dat_i, sel: m1_sel_i};

    // Every transition passes through IDLE, so a release and a new grant never share an edge.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= IDLE;
            grant_q    <= 2'b00;
            last_owner <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || last_owner)) begin
                        state   <= OWN0;
                        grant_q <= state_grant(OWN0);
                    end else if (m1_cyc_i) begin
                        state   <= OWN1;
                        grant_q <= state_grant(OWN1);
                    end
                end
                OWN0: begin
                    if (!m0_cyc_i) begin
                        state      <= IDLE;
                        grant_q    <= state_grant(IDLE);
                        last_owner <= 1'b0;
                    end
                end
                OWN1: begin
                    if (!m1_cyc_i) begin
                        state      <= IDLE;
                        grant_q    <= state_grant(IDLE);
                        last_owner <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    assign grant_o = grant_q;

    always_comb begin
        s_req = '0;
        case (state)
            OWN0:    s_req = req0;
            OWN1:    s_req = req1;
            default: s_req = '0;
        endcase
    end

`ifdef TURFIO_WB_ARB_TIMEOUT_EN
    turfio_wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .own_vld (state != IDLE),
        .own_stb (s_req.stb),
        .term    (s_ack_i | s_err_i | s_rty_i),
        .expire  (wd_expire),
        .block   (wd_block)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign wd_expire = 1'b0;
    assign wd_block  = 1'b0;
`endif

    assign timeout_o = wd_expire;

    assign s_cyc_o = s_req.cyc;
    assign s_stb_o = s_req.stb & ~wd_block;
    assign s_we_o  = s_req.we;
    assign s_adr_o = s_req.adr;
    assign s_dat_o = s_req.dat;
    assign s_sel_o = s_req.sel;

    // A watchdog expiry replaces whatever the slave returns that cycle with a single error.
    assign own_rsp = '{dat: s_dat_i,
                       ack: s_ack_i & ~wd_expire,
                       err: s_err_i | wd_expire,
                       rty: s_rty_i & ~wd_expire};

    assign m0_dat_o = own_rsp.dat;
    assign m1_dat_o = own_rsp.dat;
    assign m0_ack_o = (state == OWN0) & own_rsp.ack;
    assign m0_err_o = (state == OWN0) & own_rsp.err;
    assign m0_rty_o = (state == OWN0) & own_rsp.rty;
    assign m1_ack_o = (state == OWN1) & own_rsp.ack;
    assign m1_err_o = (state == OWN1) & own_rsp.err;
    assign m1_rty_o = (state == OWN1) & own_rsp.rty;

endmodule
